// File: rtl/vc_arbiter_if.sv
// VC FIFO read side and destination FIFO write side of the arbiter.
// The arbiter (master) pops VCs and pushes destinations; the FIFOs are the slave.
interface vc_arbiter_if #(
    parameter int DATA_WIDTH = 6
);
    logic                  vc0_empty;
    logic                  vc1_empty;
    logic [DATA_WIDTH-1:0] vc0_data;
    logic [DATA_WIDTH-1:0] vc1_data;
    logic                  vc0_pop;
    logic                  vc1_pop;
    logic                  d0_almost_full;
    logic                  d1_almost_full;
    logic                  d0_push;
    logic                  d1_push;
    logic [DATA_WIDTH-1:0] d_data;

    modport master (
        input  vc0_empty, vc1_empty, vc0_data, vc1_data,
        input  d0_almost_full, d1_almost_full,
        output vc0_pop, vc1_pop, d0_push, d1_push, d_data
    );

    modport slave (
        output vc0_empty, vc1_empty, vc0_data, vc1_data,
        output d0_almost_full, d1_almost_full,
        input  vc0_pop, vc1_pop, d0_push, d1_push, d_data
    );
endinterface

// File: rtl/vc_arbiter.sv
// Two-VC strict-priority arbiter: pops VC FIFOs while ACTIVE and routes each word
// to destination D0 or D1 by one data bit, two cycles after its pop.
module vc_arbiter #(
    parameter int DATA_WIDTH = 6,
    parameter int DEST_BIT   = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                init,
    vc_arbiter_if.master        bus,
    output logic [1:0]          state,
    output logic [7:0]          d0_count,
    output logic [7:0]          d1_count
);
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACTIVE = 2'b01,
        PAUSE  = 2'b10,
        UNUSED = 2'b11
    } state_t;

    state_t                state_q, state_d;
    logic                  vc0_pop_q, vc0_pop_d;
    logic                  vc1_pop_q, vc1_pop_d;
    logic [1:0]            tag_q, tag_d;
    logic                  d0_push_q, d0_push_d;
    logic                  d1_push_q, d1_push_d;
    logic [DATA_WIDTH-1:0] d_data_q, d_data_d;
    logic [7:0]            d0_count_q, d0_count_d;
    logic [7:0]            d1_count_q, d1_count_d;

    logic                  any_af;
    logic                  pop_ok;
    logic [DATA_WIDTH-1:0] sel_data;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            vc0_pop_q  <= 1'b0;
            vc1_pop_q  <= 1'b0;
            tag_q      <= 2'b00;
            d0_push_q  <= 1'b0;
            d1_push_q  <= 1'b0;
            d_data_q   <= '0;
            d0_count_q <= 8'd0;
            d1_count_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            vc0_pop_q  <= vc0_pop_d;
            vc1_pop_q  <= vc1_pop_d;
            tag_q      <= tag_d;
            d0_push_q  <= d0_push_d;
            d1_push_q  <= d1_push_d;
            d_data_q   <= d_data_d;
            d0_count_q <= d0_count_d;
            d1_count_q <= d1_count_d;
        end
    end

    // Handshake: a pop is a one-cycle read strobe, the VC returns its word the
    // following cycle; a push is a one-cycle write strobe qualified by d_data.
    // No ready is sampled: almost_full is assumed to leave room for 2 words in flight.
    always_comb begin
        state_d    = state_q;
        vc0_pop_d  = 1'b0;
        vc1_pop_d  = 1'b0;
        tag_d      = {vc1_pop_q, vc0_pop_q};
        d0_push_d  = 1'b0;
        d1_push_d  = 1'b0;
        d_data_d   = '0;
        sel_data   = '0;
        any_af     = bus.d0_almost_full | bus.d1_almost_full;

        case (state_q)
            IDLE:    state_d = ACTIVE;
            ACTIVE:  if (any_af) state_d = PAUSE;
            PAUSE:   if (!any_af) state_d = ACTIVE;
            default: state_d = IDLE;
        endcase
        if (!init) state_d = IDLE;

        pop_ok    = (state_q == ACTIVE) && init && !any_af;
        vc0_pop_d = pop_ok && !bus.vc0_empty;
        vc1_pop_d = pop_ok && bus.vc0_empty && !bus.vc1_empty;

        // Stage-1 tag picks the VC that was popped last cycle.
        if (tag_q[0]) begin
            sel_data = bus.vc0_data;
        end else if (tag_q[1]) begin
            sel_data = bus.vc1_data;
        end
        if (|tag_q) begin
            d_data_d  = sel_data;
            d0_push_d = !sel_data[DEST_BIT];
            d1_push_d = sel_data[DEST_BIT];
        end

        d0_count_d = d0_count_q + 8'(d0_push_d);
        d1_count_d = d1_count_q + 8'(d1_push_d);
    end

    assign bus.vc0_pop = vc0_pop_q;
    assign bus.vc1_pop = vc1_pop_q;
    assign bus.d0_push = d0_push_q;
    assign bus.d1_push = d1_push_q;
    assign bus.d_data  = d_data_q;
    assign state       = state_q;
    assign d0_count    = d0_count_q;
    assign d1_count    = d1_count_q;
endmodule

// File: tb/tb_vc_arbiter.sv
// Randomized bench for vc_arbiter against a cycle-level behavioural model with
// a scoreboard queue of words awaiting their push.
module tb_vc_arbiter;
  localparam int W  = 6;
  localparam int DB = 4;
  localparam int M_IDLE   = 0;
  localparam int M_ACTIVE = 1;
  localparam int M_PAUSE  = 2;

  // clock / reset
  logic       clk = 1'b0;
  logic       reset;
  logic       init;
  logic [1:0] state;
  logic [7:0] d0_count;
  logic [7:0] d1_count;

  always #5 clk = ~clk;

  vc_arbiter_if #(.DATA_WIDTH(W)) bus ();

  vc_arbiter #(.DATA_WIDTH(W), .DEST_BIT(DB)) dut (
    .clk      (clk),
    .reset    (reset),
    .init     (init),
    .bus      (bus),
    .state    (state),
    .d0_count (d0_count),
    .d1_count (d1_count)
  );

  int checks   = 0;
  int failures = 0;

  // model state: what the DUT outputs should show in the current cycle
  int           m_mode;
  bit           m_pop0, m_pop1;
  bit           m_prev0, m_prev1;
  int           m_cnt0, m_cnt1;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] word_src[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // one cycle: check outputs, drive inputs, advance the model, wait a cycle
  task automatic drive_cycle(input bit rst_n, input bit in_init, input bit e0, input bit e1,
                             input bit a0, input bit a1);
    logic [W-1:0] exp_d;
    logic [W-1:0] w;
    bit           exp_p0, exp_p1, pop_ok, n0, n1;
    exp_d  = '0;
    exp_p0 = 1'b0;
    exp_p1 = 1'b0;
    if (exp_q.size() > 0) begin
      exp_d  = exp_q.pop_front();
      exp_p0 = !exp_d[DB];
      exp_p1 = exp_d[DB];
    end
    check_val("state",    32'(state),       32'(m_mode));
    check_val("vc0_pop",  32'(bus.vc0_pop), 32'(m_pop0));
    check_val("vc1_pop",  32'(bus.vc1_pop), 32'(m_pop1));
    check_val("d0_push",  32'(bus.d0_push), 32'(exp_p0));
    check_val("d1_push",  32'(bus.d1_push), 32'(exp_p1));
    check_val("d_data",   32'(bus.d_data),  32'(exp_d));
    check_val("d0_count", 32'(d0_count),    32'(m_cnt0));
    check_val("d1_count", 32'(d1_count),    32'(m_cnt1));

    if (word_src.size() > 0) w = word_src.pop_front();
    else                     w = W'($urandom_range(0, (1 << W) - 1));
    reset              = rst_n;
    init               = in_init;
    bus.vc0_empty      = e0;
    bus.vc1_empty      = e1;
    bus.d0_almost_full = a0;
    bus.d1_almost_full = a1;
    bus.vc0_data       = m_prev0 ? w : '0;
    bus.vc1_data       = m_prev1 ? w : '0;

    if (!rst_n) begin
      m_mode  = M_IDLE;
      m_pop0  = 1'b0;
      m_pop1  = 1'b0;
      m_prev0 = 1'b0;
      m_prev1 = 1'b0;
      m_cnt0  = 0;
      m_cnt1  = 0;
      exp_q.delete();
    end else begin
      // a word popped last cycle arrives now and is due out next cycle
      if (m_prev0 || m_prev1) begin
        exp_q.push_back(w);
        if (w[DB]) m_cnt1 = (m_cnt1 + 1) % 256;
        else       m_cnt0 = (m_cnt0 + 1) % 256;
      end
      pop_ok = (m_mode == M_ACTIVE) && in_init && !a0 && !a1;
      n0 = pop_ok && !e0;
      n1 = pop_ok && e0 && !e1;
      if (!in_init)              m_mode = M_IDLE;
      else if (m_mode == M_IDLE) m_mode = M_ACTIVE;
      else                       m_mode = (a0 || a1) ? M_PAUSE : M_ACTIVE;
      m_prev0 = m_pop0;
      m_prev1 = m_pop1;
      m_pop0  = n0;
      m_pop1  = n1;
    end
    @(negedge clk);
  endtask

  task automatic run_random(input int n, input int rst_pct, input int off_pct,
                            input int af_pct, input int emp_pct);
    for (int i = 0; i < n; i++) begin
      drive_cycle($urandom_range(0, 99) >= rst_pct,
                  $urandom_range(0, 99) >= off_pct,
                  $urandom_range(0, 99) < emp_pct,
                  $urandom_range(0, 99) < emp_pct,
                  $urandom_range(0, 99) < af_pct,
                  $urandom_range(0, 99) < af_pct);
    end
  endtask

  initial begin
    reset              = 1'b0;
    init               = 1'b0;
    bus.vc0_empty      = 1'b1;
    bus.vc1_empty      = 1'b1;
    bus.vc0_data       = '0;
    bus.vc1_data       = '0;
    bus.d0_almost_full = 1'b0;
    bus.d1_almost_full = 1'b0;
    m_mode  = M_IDLE;
    m_pop0  = 1'b0;
    m_pop1  = 1'b0;
    m_prev0 = 1'b0;
    m_prev1 = 1'b0;
    m_cnt0  = 0;
    m_cnt1  = 0;
    @(posedge clk);
    @(negedge clk);

    // reset held, then two words from VC0: 05 to D0, 12 to D1
    drive_cycle(0, 1, 0, 0, 0, 0);
    drive_cycle(0, 1, 0, 0, 0, 0);
    word_src.push_back(6'h05);
    word_src.push_back(6'h12);
    drive_cycle(1, 1, 0, 1, 0, 0);
    drive_cycle(1, 1, 0, 1, 0, 0);
    drive_cycle(1, 1, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) drive_cycle(1, 1, 1, 1, 0, 0);

    // both VCs busy: VC0 drains first, VC1 word last
    word_src.push_back(6'h01);
    word_src.push_back(6'h01);
    word_src.push_back(6'h02);
    drive_cycle(1, 1, 0, 0, 0, 0);
    drive_cycle(1, 1, 0, 0, 0, 0);
    drive_cycle(1, 1, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) drive_cycle(1, 1, 1, 1, 0, 0);

    // backpressure while words are in flight, then release
    drive_cycle(1, 1, 0, 0, 0, 0);
    drive_cycle(1, 1, 0, 0, 0, 1);
    drive_cycle(1, 1, 0, 0, 0, 1);
    drive_cycle(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) drive_cycle(1, 1, 0, 0, 0, 0);

    // reset one cycle after a pop, then init=0 with VCs non-empty
    drive_cycle(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) drive_cycle(1, 0, 0, 0, 0, 0);

    // long runs: counter wrap, then frequent reset/init/backpressure
    run_random(1500, 0, 2, 8, 30);
    run_random(800, 3, 10, 25, 50);
    run_random(300, 0, 40, 10, 20);
    drive_cycle(1, 1, 1, 1, 0, 0);
    drive_cycle(1, 1, 1, 1, 0, 0);
    drive_cycle(1, 1, 1, 1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
